// File: rtl/axi_llc_tag_flush_seq.sv
// Way-flush sequencer for the LLC tag store: walks every set of each selected way, forwards
// dirty-eviction descriptors to write-back, and keeps the flushed-way vector that gates lookups.
module axi_llc_tag_flush_seq #(
  parameter int unsigned SetAssociativity = 8,
  parameter int unsigned NumLines         = 256,
  parameter int unsigned TagLength        = 20,
  localparam int unsigned W    = SetAssociativity,
  localparam int unsigned IdxW = (NumLines > 1) ? $clog2(NumLines) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_valid_i,
  output logic                 flush_ready_o,
  input  logic [W-1:0]         flush_ways_i,
  input  logic [W-1:0]         unflush_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [W-1:0]         flushed_o,
  output logic                 store_valid_o,
  input  logic                 store_ready_i,
  output logic [W-1:0]         store_way_o,
  output logic [IdxW-1:0]      store_index_o,
  input  logic                 res_valid_i,
  output logic                 res_ready_o,
  input  logic                 res_evict_i,
  input  logic [TagLength-1:0] res_tag_i,
  output logic                 evict_valid_o,
  input  logic                 evict_ready_i,
  output logic [W-1:0]         evict_way_o,
  output logic [IdxW-1:0]      evict_index_o,
  output logic [TagLength-1:0] evict_tag_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_EVICT,
    ST_DONE
  } state_e;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumLines - 1);

  state_e               state_q, state_d;
  logic [W-1:0]         pending_q, pending_d;
  logic [W-1:0]         way_q, way_d;
  logic [IdxW-1:0]      index_q, index_d;
  logic [TagLength-1:0] tag_q, tag_d;
  logic [W-1:0]         flushed_q, flushed_d;
  logic                 armed_q;

  logic                 advance;
  logic [W-1:0]         accept_pend;
  logic [W-1:0]         rest_pend;

  // Isolates the lowest set bit as a one-hot vector; ways are served in ascending order.
  function automatic logic [W-1:0] lowest_bit(input logic [W-1:0] v);
    return v & (~v + W'(1));
  endfunction

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    way_d       = way_q;
    index_d     = index_q;
    tag_d       = tag_q;
    flushed_d   = flushed_q;
    advance     = 1'b0;
    accept_pend = '0;
    rest_pend   = '0;

    case (state_q)
      ST_IDLE: begin
        if (armed_q) begin
          flushed_d = flushed_q & ~unflush_i;
          if (flush_valid_i) begin
            accept_pend = flush_ways_i & ~flushed_d;
            if (accept_pend == '0) begin
              state_d = ST_DONE;
            end else begin
              pending_d = accept_pend;
              way_d     = lowest_bit(accept_pend);
              index_d   = '0;
              state_d   = ST_REQ;
            end
          end
        end
      end
      ST_REQ: begin
        if (store_ready_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (res_valid_i) begin
          if (res_evict_i) begin
            tag_d   = res_tag_i;
            state_d = ST_EVICT;
          end else begin
            advance = 1'b1;
          end
        end
      end
      ST_EVICT: begin
        if (evict_ready_i) advance = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Step to the next set, or retire the way and pick the next pending one.
    if (advance) begin
      if (index_q != LastIdx) begin
        index_d = index_q + IdxW'(1);
        state_d = ST_REQ;
      end else begin
        flushed_d = flushed_q | way_q;
        rest_pend = pending_q & ~way_q;
        pending_d = rest_pend;
        index_d   = '0;
        if (rest_pend != '0) begin
          way_d   = lowest_bit(rest_pend);
          state_d = ST_REQ;
        end else begin
          state_d = ST_DONE;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      way_q     <= '0;
      index_q   <= '0;
      tag_q     <= '0;
      flushed_q <= '0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      way_q     <= way_d;
      index_q   <= index_d;
      tag_q     <= tag_d;
      flushed_q <= flushed_d;
      armed_q   <= 1'b1;
    end
  end

  // armed_q keeps flush_ready_o low while reset is asserted, so every output reads 0 in reset.
  assign flush_ready_o = (state_q == ST_IDLE) && armed_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = (state_q == ST_DONE);
  assign flushed_o     = flushed_q;

  assign store_valid_o = (state_q == ST_REQ);
  assign store_way_o   = store_valid_o ? way_q : '0;
  assign store_index_o = store_valid_o ? index_q : '0;

  assign res_ready_o   = (state_q == ST_WAIT);

  assign evict_valid_o = (state_q == ST_EVICT);
  assign evict_way_o   = evict_valid_o ? way_q : '0;
  assign evict_index_o = evict_valid_o ? index_q : '0;
  assign evict_tag_o   = evict_valid_o ? tag_q : '0;

endmodule
